esc_pwm_tx: RTL

Actuator-side transmitter for the flight-control loop. It accepts 16-bit unsigned motor commands over a valid/ready handshake and drives a standard servo-style ESC PWM pulse train: a fixed-rate period, with pulse width between MIN_US and MAX_US. It sits downstream of the PID controller, one instance per motor, and double-buffers commands so that pulse widths change only on period boundaries.

---
 rtl/esc_pwm_tx_if.sv | 19 +
 rtl/esc_pwm_tx.sv | 135 +++++++++++++
 2 files changed

// File: rtl/esc_pwm_tx_if.sv
// esc_pwm_tx_if: motor command valid/ready channel into esc_pwm_tx.
// Signals: CMD[15:0], CMD_VALID (master->slave), CMD_READY (slave->master).
interface esc_pwm_tx_if;
  logic [15:0] CMD;
  logic        CMD_VALID;
  logic        CMD_READY;

  modport master (
    output CMD,
    output CMD_VALID,
    input  CMD_READY
  );

  modport slave (
    input  CMD,
    input  CMD_VALID,
    output CMD_READY
  );
endinterface

// File: rtl/esc_pwm_tx.sv
// esc_pwm_tx: servo-style ESC PWM transmitter, commands double-buffered to period starts.
// Ports: CLK, RST_N, cmd_if.slave, ARM, PWM_OUT, UPDATE, FAILSAFE; `ESC_PWM_FAILSAFE_EN adds command-loss failsafe.
module esc_pwm_tx #(
  parameter int TICK_DIV         = 16,
  parameter int PERIOD_US        = 2500,
  parameter int MIN_US           = 1000,
  parameter int MAX_US           = 2000,
  parameter int FAILSAFE_PERIODS = 40
) (
  input  logic        CLK,
  input  logic        RST_N,
  esc_pwm_tx_if.slave cmd_if,
  input  logic        ARM,
  output logic        PWM_OUT,
  output logic        UPDATE,
  output logic        FAILSAFE
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int UW = $clog2(PERIOD_US);
  localparam int CW = (UW > 11) ? UW : 11;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [UW-1:0] US_MAX = UW'(PERIOD_US - 1);
  localparam logic [10:0] MIN_W = 11'(MIN_US);
  localparam logic [9:0] SPAN = 10'(MAX_US - MIN_US);

  logic [TW-1:0] tick_q, tick_d;
  logic [UW-1:0] us_q, us_d;
  logic          pend_full_q, pend_full_d;
  logic [10:0]   pend_q, pend_d;
  logic [10:0]   active_q, active_d;
  logic          armed_q, armed_d;
  logic          pwm_q, pwm_d;
  logic          ps, xfer, load, fs_hit;
  logic [9:0]    cmd_off;
  logic [10:0]   cmd_w;
  logic          unused_cmd_lsbs;

  assign ps   = (tick_q == '0) && (us_q == '0);
  assign xfer = cmd_if.CMD_VALID && !pend_full_q;
  assign load = ps && pend_full_q && !fs_hit;

  assign cmd_off = (cmd_if.CMD[15:6] > SPAN) ? SPAN : cmd_if.CMD[15:6];
  assign cmd_w   = MIN_W + {1'b0, cmd_off};
  assign unused_cmd_lsbs = ^cmd_if.CMD[5:0];

  assign cmd_if.CMD_READY = !pend_full_q;
  assign UPDATE  = load;
  assign PWM_OUT = pwm_q;

  always_comb begin
    tick_d = tick_q + 1'b1;
    us_d   = us_q;
    if (tick_q == TICK_MAX) begin
      tick_d = '0;
      us_d   = (us_q == US_MAX) ? '0 : us_q + 1'b1;
    end
  end

  always_comb begin
    pend_full_d = pend_full_q;
    pend_d      = pend_q;
    active_d    = active_q;
    if (fs_hit) begin
      active_d = MIN_W;
    end else if (load) begin
      active_d    = pend_q;
      pend_full_d = 1'b0;
    end
    if (xfer) begin
      pend_full_d = 1'b1;
      pend_d      = cmd_w;
    end
    // Latch drops with ARM and only re-arms at a period start: no runts.
    armed_d = ps ? ARM : (armed_q && ARM);
    // Compare against the next width so a new width applies from the PS cycle.
    pwm_d = armed_d && (CW'(us_q) < CW'(active_d));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_q      <= '0;
      us_q        <= '0;
      pend_full_q <= 1'b0;
      pend_q      <= MIN_W;
      active_q    <= MIN_W;
      armed_q     <= 1'b0;
      pwm_q       <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      us_q        <= us_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      active_q    <= active_d;
      armed_q     <= armed_d;
      pwm_q       <= pwm_d;
    end
  end

`ifdef ESC_PWM_FAILSAFE_EN
  localparam int FW = $clog2(FAILSAFE_PERIODS + 1);
  localparam logic [FW-1:0] FS_MAX = FW'(FAILSAFE_PERIODS);
  localparam logic [FW-1:0] FS_TRIP = FW'(FAILSAFE_PERIODS - 1);

  logic [FW-1:0] fs_cnt_q, fs_cnt_d;
  logic          fs_q, fs_d;

  // Counter saturates so failsafe keeps re-asserting until a command lands.
  always_comb begin
    fs_hit   = ps && (fs_cnt_q >= FS_TRIP);
    fs_cnt_d = fs_cnt_q;
    fs_d     = fs_q;
    if (ps && (fs_cnt_q != FS_MAX)) fs_cnt_d = fs_cnt_q + 1'b1;
    if (fs_hit) fs_d = 1'b1;
    else if (load) fs_d = 1'b0;
    if (xfer) fs_cnt_d = '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fs_cnt_q <= '0;
      fs_q     <= 1'b0;
    end else begin
      fs_cnt_q <= fs_cnt_d;
      fs_q     <= fs_d;
    end
  end

  assign FAILSAFE = fs_q;
`else
  logic unused_fs_cfg;
  assign unused_fs_cfg = (FAILSAFE_PERIODS != 0);
  assign fs_hit   = 1'b0;
  assign FAILSAFE = 1'b0;
`endif
endmodule
